// File: rtl/fetch_ctrl_pkg.sv
// Purpose : shared types and the redirect priority/misalign helper for fetch_ctrl.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    IDLE  = 2'd1,
    BUSY  = 2'd2,
    DRAIN = 2'd3
  } fc_state_t;

  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_BRANCH = 2'd1,
    RD_TRAP   = 2'd2
  } rd_cause_t;

  typedef struct packed {
    rd_cause_t   cause;
    logic [31:0] target;
  } redirect_t;

  localparam int unsigned DEF_TIMEOUT_CYC  = 16;
  localparam logic [31:0] DEF_FAULT_VEC    = 32'h0000_0010;
  localparam logic [31:0] DEF_MISALIGN_VEC = 32'h0000_0020;

  // Trap beats branch; a granted target that is not word aligned is
  // replaced by the misalign vector, the cause is kept.
  function automatic redirect_t redirect_sel(
    input logic        trap_req,
    input logic [31:0] trap_vec,
    input logic        br_taken,
    input logic [31:0] br_target,
    input logic [31:0] misalign_vec
  );
    redirect_t r;
    r.cause  = RD_NONE;
    r.target = '0;
    if (trap_req) begin
      r.cause  = RD_TRAP;
      r.target = trap_vec;
    end else if (br_taken) begin
      r.cause  = RD_BRANCH;
      r.target = br_target;
    end
    if ((r.cause != RD_NONE) && (r.target[1:0] != 2'b00)) begin
      r.target = misalign_vec;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_arb.sv
// Purpose : combinational redirect arbiter (trap > branch) with misalign substitution.
// Latency : 0 cycles, purely combinational.
// Backpr. : none; the result is consumed or ignored by the caller in the same cycle.
// Ports   : trap_req/trap_vec, br_taken/br_target in; rd_cause (rd_cause_t encoding), rd_tgt out.
module fetch_ctrl_redirect_arb
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] MISALIGN_VEC = DEF_MISALIGN_VEC
) (
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [1:0]  rd_cause,
  output logic [31:0] rd_tgt
);

  redirect_t sel;

  always_comb begin
    sel      = redirect_sel(trap_req, trap_vec, br_taken, br_target, MISALIGN_VEC);
    rd_cause = sel.cause;
    rd_tgt   = sel.target;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Purpose : PC/fetch sequencer: imem req/ack handshake, redirect arbitration, held redirect, timeout fault.
// Latency : outputs are combinational from state and inputs; the PC register acts on them at the next edge.
// Backpr. : stall_pc holds the PC while a fetch is outstanding, during hazard_stall and in BOOT.
// Ports   : i_clk, i_rst (async, active-low); pc, hazard_stall, br_taken/br_target, trap_req/trap_vec,
//           imem_ack in; imem_req/imem_addr, instr_valid, stall_pc, pc_update_control/pc_update_val,
//           flush_if, flush_id, fetch_fault out.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter logic [31:0] FAULT_VEC    = DEF_FAULT_VEC,
  parameter logic [31:0] MISALIGN_VEC = DEF_MISALIGN_VEC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] pc,
  input  logic        hazard_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic        stall_pc,
  output logic        pc_update_control,
  output logic [31:0] pc_update_val,
  output logic        flush_if,
  output logic        flush_id,
  output logic        fetch_fault
);

  localparam int unsigned    TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT_CYC);

  fc_state_t   state, state_nxt;
  logic        pend_vld, pend_vld_nxt;
  rd_cause_t   pend_cause, pend_cause_nxt;
  logic [31:0] pend_tgt, pend_tgt_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;

  logic [1:0]  arb_cause_raw;
  rd_cause_t   arb_cause;
  logic [31:0] arb_tgt;

  // Pending redirect as it would look after folding in this cycle's request.
  logic        eff_vld;
  rd_cause_t   eff_cause;
  logic [31:0] eff_tgt;

  logic        redir_go;
  logic [31:0] redir_tgt;

  fetch_ctrl_redirect_arb #(
    .MISALIGN_VEC (MISALIGN_VEC)
  ) u_arb (
    .trap_req  (trap_req),
    .trap_vec  (trap_vec),
    .br_taken  (br_taken),
    .br_target (br_target),
    .rd_cause  (arb_cause_raw),
    .rd_tgt    (arb_tgt)
  );

  assign arb_cause = rd_cause_t'(arb_cause_raw);

  // A new trap always replaces what is held; a new branch only replaces
  // nothing or another branch, never a held trap.
  always_comb begin
    eff_vld   = pend_vld;
    eff_cause = pend_cause;
    eff_tgt   = pend_tgt;
    if ((arb_cause == RD_TRAP) ||
        ((arb_cause == RD_BRANCH) && !(pend_vld && (pend_cause == RD_TRAP)))) begin
      eff_vld   = 1'b1;
      eff_cause = arb_cause;
      eff_tgt   = arb_tgt;
    end
  end

  always_comb begin
    state_nxt         = state;
    pend_vld_nxt      = pend_vld;
    pend_cause_nxt    = pend_cause;
    pend_tgt_nxt      = pend_tgt;
    tcnt_nxt          = tcnt;
    imem_req          = 1'b0;
    instr_valid       = 1'b0;
    stall_pc          = 1'b0;
    pc_update_control = 1'b0;
    pc_update_val     = '0;
    flush_if          = 1'b0;
    flush_id          = 1'b0;
    fetch_fault       = 1'b0;
    redir_go          = 1'b0;
    redir_tgt         = '0;

    unique case (state)
      BOOT: begin
        stall_pc  = 1'b1;
        state_nxt = IDLE;
      end

      IDLE: begin
        if (arb_cause != RD_NONE) begin
          redir_go  = 1'b1;
          redir_tgt = arb_tgt;
        end else if (hazard_stall) begin
          stall_pc = 1'b1;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            instr_valid = 1'b1;
          end else begin
            stall_pc  = 1'b1;
            state_nxt = BUSY;
            tcnt_nxt  = TW'(1);
          end
        end
      end

      // BUSY and DRAIN differ only in whether a redirect is held; in DRAIN
      // eff_vld is always set, so the fetched word is never delivered.
      BUSY, DRAIN: begin
        imem_req = 1'b1;
        stall_pc = 1'b1;
        if (imem_ack) begin
          state_nxt      = IDLE;
          tcnt_nxt       = '0;
          pend_vld_nxt   = 1'b0;
          pend_cause_nxt = RD_NONE;
          if (eff_vld) begin
            redir_go  = 1'b1;
            redir_tgt = eff_tgt;
          end else begin
            instr_valid = 1'b1;
            stall_pc    = 1'b0;
          end
        end else if (tcnt == TMAX) begin
          // Give up on the fetch; a held trap still takes precedence over the fault vector.
          imem_req       = 1'b0;
          fetch_fault    = 1'b1;
          redir_go       = 1'b1;
          redir_tgt      = (eff_vld && (eff_cause == RD_TRAP)) ? eff_tgt : FAULT_VEC;
          state_nxt      = IDLE;
          tcnt_nxt       = '0;
          pend_vld_nxt   = 1'b0;
          pend_cause_nxt = RD_NONE;
        end else begin
          tcnt_nxt = (tcnt == TMAX) ? tcnt : tcnt + TW'(1);
          if (eff_vld) begin
            state_nxt      = DRAIN;
            pend_vld_nxt   = 1'b1;
            pend_cause_nxt = eff_cause;
            pend_tgt_nxt   = eff_tgt;
          end
        end
      end
    endcase

    if (redir_go) begin
      pc_update_control = 1'b1;
      pc_update_val     = redir_tgt;
      stall_pc          = 1'b0;
      flush_if          = 1'b1;
      flush_id          = 1'b1;
      instr_valid       = 1'b0;
    end
  end

  assign imem_addr = imem_req ? pc : '0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= BOOT;
      pend_vld   <= 1'b0;
      pend_cause <= RD_NONE;
      pend_tgt   <= '0;
      tcnt       <= '0;
    end else begin
      state      <= state_nxt;
      pend_vld   <= pend_vld_nxt;
      pend_cause <= pend_cause_nxt;
      pend_tgt   <= pend_tgt_nxt;
      tcnt       <= tcnt_nxt;
    end
  end

endmodule
